// File: rtl/npu_seq_ctrl.sv
// npu_seq_ctrl: job sequencer for the NPU datapath.
//
// Steps one job at a time through IDLE, LOAD, COMPUTE (N cycles), RELU,
// CAPTURE, WRITE and FINISH. It drives the control strobes for input_buffer,
// mac_module, relu_module and auto_comparator. It then streams the captured
// lane results byte-wise into the output FIFO and honours FIFO backpressure.
//
// Ports:
//   CLKEXT, RST_GLO        clock (rising edge), asynchronous active-high reset
//   START, ABORT           job request (one sync flop), job termination
//   CFG_*                  per-job configuration, latched when LOAD is entered
//   LANE_DATA              post-ReLU lane results, lane 0 in the LSBs
//   FIFO_FULL              output FIFO backpressure
//   EN_*/RST_*             datapath strobes, Moore-decoded from the state
//   FIFO_WR_EN, FIFO_DATA  output FIFO write port
//   SEL_OUT, BYPASS_RELU   registered per-job selects
//   BUSY, DONE, ERR_ABORT  job status
//   JOB_CNT                count of completed jobs (wraps)
module npu_seq_ctrl #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     CLKEXT,
  input  logic                     RST_GLO,
  input  logic                     START,
  input  logic                     ABORT,
  input  logic [CNT_W-1:0]         CFG_MAC_CYCLES,
  input  logic                     CFG_BYPASS_RELU,
  input  logic [2:0]               CFG_SEL_OUT,
  input  logic [LANES*ACC_W-1:0]   LANE_DATA,
  input  logic                     FIFO_FULL,
  output logic                     EN_BUF_IN,
  output logic                     EN_MAC,
  output logic                     RST_MAC,
  output logic                     EN_RELU,
  output logic                     BYPASS_RELU,
  output logic                     EN_COMP,
  output logic                     RST_COMP,
  output logic                     FIFO_WR_EN,
  output logic [BYTE_W-1:0]        FIFO_DATA,
  output logic [2:0]               SEL_OUT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR_ABORT,
  output logic [7:0]               JOB_CNT
);

  localparam int unsigned BytesPerLane = ACC_W / BYTE_W;
  localparam int unsigned NumBytes     = LANES * BytesPerLane;
  localparam int unsigned PtrW         = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StCompute = 3'd2;
  localparam logic [2:0] StRelu    = 3'd3;
  localparam logic [2:0] StCapture = 3'd4;
  localparam logic [2:0] StWrite   = 3'd5;
  localparam logic [2:0] StFinish  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic              start_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PtrW-1:0]   ptr_q;
  logic [BYTE_W-1:0] shadow_q [NumBytes];
  logic [2:0]        sel_q;
  logic              bypass_q;
  logic              err_q;
  logic [7:0]        job_cnt_q;

  logic busy;
  logic abort_ok;
  logic wr_en;
  logic enter_load;

  assign busy       = (state_q == StLoad) || (state_q == StCompute) || (state_q == StRelu) ||
                      (state_q == StCapture) || (state_q == StWrite);
  // ABORT is ignored in IDLE and FINISH
  assign abort_ok   = ABORT && busy;
  assign wr_en      = (state_q == StWrite) && !FIFO_FULL;
  assign enter_load = (state_q == StIdle) && (state_d == StLoad);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start_q) state_d = StLoad;
      StLoad:    state_d = StCompute;
      StCompute: if (cnt_q == n_q - CNT_W'(1)) state_d = StRelu;
      StRelu:    state_d = StCapture;
      StCapture: state_d = StWrite;
      StWrite:   if (wr_en && (ptr_q == PtrW'(NumBytes - 1))) state_d = StFinish;
      StFinish:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    // abort outranks every other transition, including the last byte
    if (abort_ok) state_d = StIdle;
  end

  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      n_q       <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
      bypass_q  <= 1'b0;
      err_q     <= 1'b0;
      job_cnt_q <= '0;
      for (int k = 0; k < NumBytes; k++) shadow_q[k] <= '0;
    end else begin
      state_q <= state_d;
      start_q <= START;
      if (enter_load) begin
        n_q      <= (CFG_MAC_CYCLES == '0) ? CNT_W'(1) : CFG_MAC_CYCLES;
        bypass_q <= CFG_BYPASS_RELU;
        sel_q    <= CFG_SEL_OUT;
        err_q    <= 1'b0;
      end
      if (abort_ok) err_q <= 1'b1;
      if (state_q == StLoad) begin
        cnt_q <= '0;
      end else if (state_q == StCompute) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // shadow is stored in emission order: lane 0 first, MSB first in a lane
      if (state_q == StCapture) begin
        ptr_q <= '0;
        for (int k = 0; k < NumBytes; k++) begin
          shadow_q[k] <= LANE_DATA[(k / BytesPerLane) * ACC_W + ACC_W
                                   - BYTE_W * ((k % BytesPerLane) + 1) +: BYTE_W];
        end
      end else if (wr_en) begin
        ptr_q <= ptr_q + PtrW'(1);
      end
      if (state_q == StFinish) job_cnt_q <= job_cnt_q + 8'd1;
    end
  end

  assign EN_BUF_IN   = (state_q == StLoad);
  assign EN_MAC      = (state_q == StCompute);
  assign RST_MAC     = (state_q == StIdle) || (state_q == StLoad);
  assign EN_RELU     = (state_q == StRelu);
  assign EN_COMP     = (state_q == StCapture);
  assign RST_COMP    = (state_q == StIdle);
  assign FIFO_WR_EN  = wr_en;
  assign FIFO_DATA   = (state_q == StWrite) ? shadow_q[ptr_q] : '0;
  assign BUSY        = busy;
  assign DONE        = (state_q == StFinish);
  assign SEL_OUT     = sel_q;
  assign BYPASS_RELU = bypass_q;
  assign ERR_ABORT   = err_q;
  assign JOB_CNT     = job_cnt_q;

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Bench for npu_seq_ctrl. Each job is described by its configuration, lane data,
// a FIFO_FULL schedule and an optional abort/reset cycle. A per-job timeline
// model then derives the expected outputs for every cycle.
module tb_npu_seq_ctrl;

  localparam int unsigned LANES  = 2;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned W      = LANES * ACC_W;
  localparam int unsigned BPL    = ACC_W / BYTE_W;
  localparam int unsigned NB     = LANES * BPL;

  logic              CLKEXT, RST_GLO, START, ABORT;
  logic [CNT_W-1:0]  CFG_MAC_CYCLES;
  logic              CFG_BYPASS_RELU;
  logic [2:0]        CFG_SEL_OUT;
  logic [W-1:0]      LANE_DATA;
  logic              FIFO_FULL;
  logic              EN_BUF_IN, EN_MAC, RST_MAC, EN_RELU, BYPASS_RELU, EN_COMP, RST_COMP;
  logic              FIFO_WR_EN, BUSY, DONE, ERR_ABORT;
  logic [BYTE_W-1:0] FIFO_DATA;
  logic [2:0]        SEL_OUT;
  logic [7:0]        JOB_CNT;

  npu_seq_ctrl #(.LANES(LANES), .ACC_W(ACC_W), .BYTE_W(BYTE_W), .CNT_W(CNT_W)) dut (
    .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .START(START), .ABORT(ABORT),
    .CFG_MAC_CYCLES(CFG_MAC_CYCLES), .CFG_BYPASS_RELU(CFG_BYPASS_RELU),
    .CFG_SEL_OUT(CFG_SEL_OUT), .LANE_DATA(LANE_DATA), .FIFO_FULL(FIFO_FULL),
    .EN_BUF_IN(EN_BUF_IN), .EN_MAC(EN_MAC), .RST_MAC(RST_MAC), .EN_RELU(EN_RELU),
    .BYPASS_RELU(BYPASS_RELU), .EN_COMP(EN_COMP), .RST_COMP(RST_COMP),
    .FIFO_WR_EN(FIFO_WR_EN), .FIFO_DATA(FIFO_DATA), .SEL_OUT(SEL_OUT), .BUSY(BUSY),
    .DONE(DONE), .ERR_ABORT(ERR_ABORT), .JOB_CNT(JOB_CNT)
  );

  initial CLKEXT = 1'b0;
  always #5 CLKEXT = ~CLKEXT;

  int n_tests = 0;
  int n_fail  = 0;

  // model state carried between jobs
  logic [7:0] jobcnt_m = 8'd0;
  logic       err_m    = 1'b0;
  logic [3:0] bsel_m   = 4'd0;  // {bypass, sel}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] strobes();
    return {EN_BUF_IN, EN_MAC, RST_MAC, EN_RELU, EN_COMP, RST_COMP, FIFO_WR_EN, BUSY, DONE};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_strb"}, 32'(strobes()), 32'(9'b001001000));
    check({tag, "_data"}, 32'(FIFO_DATA), 32'd0);
    check({tag, "_bsel"}, 32'({BYPASS_RELU, SEL_OUT}), 32'd0);
    check({tag, "_err"},  32'(ERR_ABORT), 32'd0);
    check({tag, "_jcnt"}, 32'(JOB_CNT), 32'd0);
  endtask

  // abort_k: -1 none, 0 random cycle, >0 that cycle. rst_k: -1 none, else reset after
  // that cycle's checks. chained: START already high and previous job just finished.
  task automatic run_job(input logic [W-1:0] ld, input int n_raw, input logic byp,
                         input logic [2:0] sel, input logic [31:0] full_mask,
                         input int full_pct, input int abort_k, input int rst_k,
                         input bit chained, input bit hold);
    bit          full [512];
    logic [7:0]  bytes [NB];
    logic [W-1:0] tmp;
    int n, w0, kl, ka, k_end, wcount, ph;
    bit aborted, did_rst;
    logic [8:0] es;
    logic [7:0] ed;

    n = (n_raw == 0) ? 1 : n_raw;
    for (int b = 0; b < NB; b++) begin
      tmp = ld >> ((b / BPL) * ACC_W + ACC_W - BYTE_W * ((b % BPL) + 1));
      bytes[b] = tmp[7:0];
    end
    w0 = n + 4;
    for (int k = 0; k < 512; k++) begin
      full[k] = 1'b0;
      if (k >= w0 && k < 400)
        full[k] = ((k - w0 < 32) && full_mask[k - w0]) || ($urandom_range(99, 0) < full_pct);
    end
    wcount = 0;
    kl = w0;
    while (1) begin
      if (!full[kl]) wcount++;
      if (wcount == NB) break;
      kl++;
    end
    ka = (abort_k < 0) ? 100000 : (abort_k == 0) ? int'($urandom_range(kl, 1)) : abort_k;
    aborted = (ka <= kl);
    k_end   = aborted ? ka + 1 : (hold ? kl + 1 : kl + 2);
    did_rst = 1'b0;

    if (!chained) begin
      @(posedge CLKEXT); #1;
      START = 1'b1;
    end
    @(posedge CLKEXT); #1;
    START = hold;
    CFG_MAC_CYCLES = n_raw[CNT_W-1:0];
    CFG_BYPASS_RELU = byp;
    CFG_SEL_OUT = sel;
    LANE_DATA = ld;
    FIFO_FULL = 1'b0;
    ABORT = 1'b0;
    @(negedge CLKEXT);
    check("idle_strb", 32'(strobes()), 32'(9'b001001000));

    wcount = 0;
    for (int k = 1; k <= k_end; k++) begin
      @(posedge CLKEXT); #1;
      FIFO_FULL = full[k];
      ABORT = (k == ka);
      START = hold ? 1'b1 : ((k <= kl && k < ka) ? 1'($urandom_range(1, 0)) : 1'b0);
      if (k == 2) begin
        CFG_MAC_CYCLES = CNT_W'($urandom);
        CFG_BYPASS_RELU = 1'($urandom);
        CFG_SEL_OUT = 3'($urandom);
      end
      @(negedge CLKEXT);
      // 0 idle, 1 load, 2 compute, 3 relu, 4 capture, 5 write, 6 finish
      if (k > ka || k > kl + 1) ph = 0;
      else if (k == 1)          ph = 1;
      else if (k <= n + 1)      ph = 2;
      else if (k == n + 2)      ph = 3;
      else if (k == n + 3)      ph = 4;
      else if (k <= kl)         ph = 5;
      else                      ph = 6;
      es = {ph == 1, ph == 2, ph <= 1, ph == 3, ph == 4, ph == 0,
            (ph == 5) && !full[k], (ph >= 1) && (ph <= 5), ph == 6};
      ed = (ph == 5) ? bytes[wcount] : 8'd0;
      check($sformatf("strb k=%0d", k), 32'(strobes()), 32'(es));
      check($sformatf("data k=%0d", k), 32'(FIFO_DATA), 32'(ed));
      check($sformatf("bsel k=%0d", k), 32'({BYPASS_RELU, SEL_OUT}), 32'({byp, sel}));
      check($sformatf("err k=%0d", k), 32'(ERR_ABORT), 32'(k > ka));
      check($sformatf("jcnt k=%0d", k), 32'(JOB_CNT),
            32'(jobcnt_m + ((!aborted && k >= kl + 2) ? 8'd1 : 8'd0)));
      if (ph == 5 && !full[k]) wcount++;
      if (k == rst_k) begin
        START = 1'b0;
        ABORT = 1'b0;
        #2 RST_GLO = 1'b1;
        #1 check_reset_vals("midjob_rst");
        @(posedge CLKEXT); #1;
        RST_GLO = 1'b0;
        did_rst = 1'b1;
        break;
      end
    end
    ABORT = 1'b0;
    FIFO_FULL = 1'b0;
    START = hold;
    if (did_rst) begin
      jobcnt_m = 8'd0; err_m = 1'b0; bsel_m = 4'd0;
    end else begin
      bsel_m = {byp, sel};
      err_m  = aborted;
      if (!aborted) jobcnt_m = jobcnt_m + 8'd1;
    end
  endtask

  initial begin
    logic [7:0] jc_before;
    RST_GLO = 1'b0; START = 1'b0; ABORT = 1'b0; FIFO_FULL = 1'b0;
    CFG_MAC_CYCLES = '0; CFG_BYPASS_RELU = 1'b0; CFG_SEL_OUT = '0; LANE_DATA = '0;
    #2 RST_GLO = 1'b1;
    #1 check_reset_vals("por");
    repeat (2) @(posedge CLKEXT);
    #1 RST_GLO = 1'b0;

    // basic job, then same job with 3 full cycles after the first byte
    run_job({16'hABCD, 16'h1234}, 4, 1'b0, 3'd0, 32'h0, 0, -1, -1, 1'b0, 1'b0);
    check("jobcnt_1", 32'(JOB_CNT), 32'd1);
    run_job({16'hABCD, 16'h1234}, 4, 1'b0, 3'd0, 32'hE, 0, -1, -1, 1'b0, 1'b0);
    // zero MAC cycles, selects visible from LOAD
    run_job({16'h5A5A, 16'hC3F0}, 0, 1'b1, 3'b101, 32'h0, 0, -1, -1, 1'b0, 1'b0);
    // abort on the second COMPUTE cycle
    run_job({16'hABCD, 16'h1234}, 4, 1'b0, 3'd2, 32'h0, 0, 3, -1, 1'b0, 1'b0);
    check("err_sticky", 32'(ERR_ABORT), 32'd1);
    // reset after two bytes, then a clean job
    run_job({16'hABCD, 16'h1234}, 4, 1'b0, 3'd1, 32'h0, 0, -1, 9, 1'b0, 1'b0);
    run_job({16'hABCD, 16'h1234}, 4, 1'b0, 3'd1, 32'h0, 0, -1, -1, 1'b0, 1'b0);
    // START held high across three jobs
    jc_before = jobcnt_m;
    run_job({16'h0102, 16'h0304}, 2, 1'b0, 3'd3, 32'h0, 0, -1, -1, 1'b0, 1'b1);
    run_job({16'h1112, 16'h1314}, 3, 1'b1, 3'd4, 32'h0, 0, -1, -1, 1'b1, 1'b1);
    run_job({16'h2122, 16'h2324}, 1, 1'b0, 3'd6, 32'h0, 0, -1, -1, 1'b1, 1'b0);
    check("jobcnt_chain", 32'(JOB_CNT), 32'(jc_before + 8'd3));

    for (int j = 0; j < 25; j++) begin
      run_job(W'({$urandom, $urandom}), int'($urandom_range(6, 0)), 1'($urandom),
              3'($urandom), 32'h0, 30, ($urandom_range(3, 0) == 0) ? 0 : -1, -1,
              1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
